umi_req_arbiter: RTL and testbench
==================================

// Module: umi_req_arbiter
// PURPOSE
// - Shares one UMI request channel (e.g. a umi_fifo feeding umi_mem_agent) between N UMI hosts.
// - Arbitration is round-robin and message-atomic: a grant is held from the first beat to the
//   EOM beat, so beats from different hosts never interleave.
// - Zero-latency mux: the selected input drives the output in the same cycle. No data storage.
// PARAMETERS
// - N      4    number of requesting hosts (2..16)
// - CW     32   UMI command width
// - AW     64   UMI address width
// - DW     128  UMI data width
// - EOMBIT 22   bit index of EOM in cmd
// PORTS
// - clk              in   1     clock; all state updates on rising edge
// - reset            in   1     synchronous reset, active-high
// - arb_mask         in   N     1 = host excluded from new grants (does not break a held grant)
// - uhost_req_valid  in   N     per-host valid
// - uhost_req_cmd    in   N*CW  per-host cmd, host i at [i*CW +: CW]
// - uhost_req_dstaddr in  N*AW  per-host dstaddr, packed as cmd
// - uhost_req_srcaddr in  N*AW  per-host srcaddr, packed as cmd
// - uhost_req_data   in   N*DW  per-host data, packed as cmd
// - uhost_req_ready  out  N     per-host ready; only the granted host may see 1
// - udev_req_valid   out  1     shared output valid
// - udev_req_cmd     out  CW    cmd of the granted host
// - udev_req_dstaddr out  AW    dstaddr of the granted host
// - udev_req_srcaddr out  AW    srcaddr of the granted host
// - udev_req_data    out  DW    data of the granted host
// - udev_req_ready   in   1     downstream ready
// - arb_owner        out  $clog2(N)  index of the current or held grant (debug/observability)
// - arb_locked       out  1     1 while a message is in progress (grant held)
// BEHAVIOUR
// - State: IDLE / LOCKED, plus registers owner[$clog2(N)] and ptr[$clog2(N)] (priority start).
// - Reset: state=IDLE, owner=0, ptr=0. Outputs on reset: udev_req_valid=0, uhost_req_ready=0,
//   arb_locked=0, arb_owner=0. The mux is forced off while reset=1.
// - IDLE selection: sel = first i starting at ptr (cyclic) with valid[i] & ~arb_mask[i].
//   With no candidate: udev_req_valid=0 and uhost_req_ready=0.
// - LOCKED selection: sel = owner, and arb_mask is ignored.
// - Datapath: udev_req_* = host[sel] fields. udev_req_valid = valid[sel].
//   uhost_req_ready[sel] = udev_req_ready; every other host's ready = 0.
// - Transitions (evaluated when udev_req_valid=1):
//   - ready & cmd[EOMBIT]: go to IDLE, ptr <= sel+1 mod N.
//   - ready & ~EOM: go to LOCKED, owner <= sel.
//   - ~ready: go to LOCKED, owner <= sel. Once valid is shown to the device, the choice must
//     not change.
// - LOCKED with valid[owner]=0 (a gap mid-message): stay LOCKED with output valid=0.
//   No other host may be granted.
// - An EOM beat accepted on the same cycle that another host raises valid: the new host is
//   eligible next cycle via the updated ptr.
// - Single-host traffic: back-to-back EOM messages from one host stream at 1 beat/cycle.
// - Reset asserted mid-message: state is abandoned immediately; there is no flush.
// - arb_owner = sel when IDLE with a candidate, owner when LOCKED, otherwise the last owner.
// STRUCTURE
// - Shared package umi_pkg holds the UMI_EOM_BIT constant and the cmd field offsets.
// - Sub-module umi_rr_pick (N-input cyclic priority encoder: req, ptr -> gnt index, any) holds
//   the combinational selection logic.
// - The top level holds the FSM, ptr/owner registers and the field mux.
// TESTING
// - Reset: hold reset=1 with all valids=1 -> udev_req_valid=0, all ready=0, arb_owner=0.
// - N=4, hosts 0..3 each send one single-beat EOM message, udev_req_ready=1 -> grants go
//   0,1,2,3 on consecutive cycles. Repeat -> 0,1,2,3 again.
// - Host 1 sends a 3-beat message (EOM on beat 3) while host 2 is valid. Stall ready on beat 2
//   for 2 cycles -> host 1's beats stay contiguous on output, ready[2]=0 throughout, host 2 is
//   granted on the cycle after the EOM.
// - Host 0 drops valid between beats 1 and 2 while host 3 is valid -> arb_locked=1,
//   udev_req_valid=0, ready[3]=0 until host 0 completes EOM.
// - arb_mask=4'b0001 with hosts 0 and 1 valid -> host 1 is granted. Setting mask bit 1 during
//   host 1's locked message -> the message still completes.
// - Reset pulse during a locked message -> next cycle: IDLE, ptr=0, host 0 wins if valid.

Source files
------------

// File: rtl/umi_pkg.sv
// Shared UMI constants and the arbiter state encoding.
package umi_pkg;

   localparam int UMI_OPCODE_LSB = 0;
   localparam int UMI_OPCODE_W   = 5;
   localparam int UMI_SIZE_LSB   = 5;
   localparam int UMI_LEN_LSB    = 8;
   localparam int UMI_EOM_BIT    = 22;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   // Cyclic successor of idx within 0..n-1.
   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/umi_req_arbiter_if.sv
// N UMI request hosts on one side, a single UMI request device on the other.
interface umi_req_arbiter_if #(
   parameter int N  = 4,
   parameter int CW = 32,
   parameter int AW = 64,
   parameter int DW = 128
);
   logic [N-1:0]    uhost_req_valid;
   logic [N*CW-1:0] uhost_req_cmd;
   logic [N*AW-1:0] uhost_req_dstaddr;
   logic [N*AW-1:0] uhost_req_srcaddr;
   logic [N*DW-1:0] uhost_req_data;
   logic [N-1:0]    uhost_req_ready;

   logic            udev_req_valid;
   logic [CW-1:0]   udev_req_cmd;
   logic [AW-1:0]   udev_req_dstaddr;
   logic [AW-1:0]   udev_req_srcaddr;
   logic [DW-1:0]   udev_req_data;
   logic            udev_req_ready;

   modport slave (
      input  uhost_req_valid, uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr,
      input  uhost_req_data, udev_req_ready,
      output uhost_req_ready, udev_req_valid, udev_req_cmd, udev_req_dstaddr,
      output udev_req_srcaddr, udev_req_data
   );

   modport master (
      output uhost_req_valid, uhost_req_cmd, uhost_req_dstaddr, uhost_req_srcaddr,
      output uhost_req_data, udev_req_ready,
      input  uhost_req_ready, udev_req_valid, udev_req_cmd, udev_req_dstaddr,
      input  udev_req_srcaddr, udev_req_data
   );
endinterface

// File: rtl/umi_rr_pick.sv
// Cyclic priority encoder: first set req bit at or after ptr, wrapping at N.
module umi_rr_pick #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [PW-1:0] gnt,
   output logic          any
);

   logic [PW-1:0] idx;

   // Scan from the farthest offset back to ptr so the nearest hit is written last.
   always_comb begin
      gnt = '0;
      any = 1'b0;
      idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = PW'((int'(ptr) + i) % N);
         if (req[idx]) begin
            gnt = idx;
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/umi_req_arbiter.sv
// Round-robin, message-atomic arbiter sharing one UMI request channel among N hosts.
module umi_req_arbiter
   import umi_pkg::*;
#(
   parameter  int N      = 4,
   parameter  int CW     = 32,
   parameter  int AW     = 64,
   parameter  int DW     = 128,
   parameter  int EOMBIT = UMI_EOM_BIT,
   localparam int PW     = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [N-1:0]  arb_mask,
   umi_req_arbiter_if.slave bus,
   output logic [PW-1:0] arb_owner,
   output logic          arb_locked
);

   arb_state_e    state_q, state_d;
   logic [PW-1:0] owner_q, owner_d;
   logic [PW-1:0] ptr_q, ptr_d;

   logic [PW-1:0] pick_gnt;
   logic          pick_any;
   logic [PW-1:0] sel;
   logic          have;
   logic          grant_en;
   logic          out_valid;

   logic [CW-1:0] cmd_a     [N];
   logic [AW-1:0] dstaddr_a [N];
   logic [AW-1:0] srcaddr_a [N];
   logic [DW-1:0] data_a    [N];

   umi_rr_pick #(.N(N)) u_pick (
      .req (bus.uhost_req_valid & ~arb_mask),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .any (pick_any)
   );

   for (genvar g = 0; g < N; g++) begin : g_host
      assign cmd_a[g]     = bus.uhost_req_cmd[g*CW +: CW];
      assign dstaddr_a[g] = bus.uhost_req_dstaddr[g*AW +: AW];
      assign srcaddr_a[g] = bus.uhost_req_srcaddr[g*AW +: AW];
      assign data_a[g]    = bus.uhost_req_data[g*DW +: DW];
      assign bus.uhost_req_ready[g] = grant_en & (sel == PW'(g)) & bus.udev_req_ready;
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      if (state_q == ARB_LOCKED) begin
         sel  = owner_q;
         have = 1'b1;
      end else begin
         sel  = pick_gnt;
         have = pick_any;
      end
      grant_en  = have & ~reset;
      out_valid = grant_en & bus.uhost_req_valid[sel];
      // Once a beat is on the output the choice sticks until its EOM is accepted.
      if (out_valid) begin
         owner_d = sel;
         if (bus.udev_req_ready && cmd_a[sel][EOMBIT]) begin
            state_d = ARB_IDLE;
            ptr_d   = PW'(rr_next(int'(sel), N));
         end else begin
            state_d = ARB_LOCKED;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ARB_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   assign bus.udev_req_valid   = out_valid;
   assign bus.udev_req_cmd     = cmd_a[sel];
   assign bus.udev_req_dstaddr = dstaddr_a[sel];
   assign bus.udev_req_srcaddr = srcaddr_a[sel];
   assign bus.udev_req_data    = data_a[sel];

   assign arb_locked = ~reset & (state_q == ARB_LOCKED);
   assign arb_owner  = reset ? '0 :
                       ((state_q == ARB_IDLE) && pick_any) ? pick_gnt : owner_q;

endmodule

// File: tb/tb_umi_req_arbiter.sv
// Directed bench for umi_req_arbiter: per-host beat queues drive the inputs, a monitor
// matches every accepted output beat against a queue of hand-ordered expected beats.
module tb_umi_req_arbiter;
   import umi_pkg::*;

   localparam int N  = 4;
   localparam int CW = 32;
   localparam int AW = 64;
   localparam int DW = 128;
   localparam int PW = 2;

   logic          clk = 1'b0;
   logic          reset;
   logic [N-1:0]  arb_mask;
   logic [PW-1:0] arb_owner;
   logic          arb_locked;

   umi_req_arbiter_if #(.N(N), .CW(CW), .AW(AW), .DW(DW)) bus ();

   umi_req_arbiter #(.N(N), .CW(CW), .AW(AW), .DW(DW), .EOMBIT(UMI_EOM_BIT)) dut (
      .clk        (clk),
      .reset      (reset),
      .arb_mask   (arb_mask),
      .bus        (bus),
      .arb_owner  (arb_owner),
      .arb_locked (arb_locked)
   );

   always #5 clk = ~clk;

   typedef struct packed { logic bubble; logic eom; logic [7:0] tag; } beat_t;
   typedef struct packed { logic [7:0] host; logic [7:0] tag; logic eom; } exp_t;

   beat_t        hq [N][$];
   exp_t         expq [$];
   logic [N-1:0] acc;
   logic [N-1:0] drv_bubble;
   int           checks = 0;
   int           errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic push(input int h, input logic [7:0] tag, input logic eom);
      hq[h].push_back({1'b0, eom, tag});
   endtask

   task automatic gap(input int h);
      hq[h].push_back({1'b1, 1'b0, 8'h00});
   endtask

   task automatic expect_beat(input int h, input logic [7:0] tag, input logic eom);
      expq.push_back({8'(h), tag, eom});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int left;
      left = 0;
      for (int c = 0; c < 300; c++) begin
         left = expq.size();
         for (int i = 0; i < N; i++) left += hq[i].size();
         if (left == 0) break;
         tick();
      end
      check(name, 64'(left), 64'd0);
   endtask

   // Host models: pop the head once accepted (or once a bubble has been shown), present the next.
   initial begin
      bus.uhost_req_valid   = '0;
      bus.uhost_req_cmd     = '0;
      bus.uhost_req_dstaddr = '0;
      bus.uhost_req_srcaddr = '0;
      bus.uhost_req_data    = '0;
      drv_bubble            = '0;
      forever begin
         @(posedge clk);
         #2;
         for (int i = 0; i < N; i++) begin
            beat_t b;
            logic [AW-1:0] addr;
            if (hq[i].size() > 0 && (acc[i] || drv_bubble[i])) void'(hq[i].pop_front());
            if (hq[i].size() == 0) begin
               bus.uhost_req_valid[i] = 1'b0;
               drv_bubble[i]          = 1'b0;
            end else begin
               b    = hq[i][0];
               addr = {48'h0, 8'(i), b.tag};
               bus.uhost_req_valid[i]            = ~b.bubble;
               drv_bubble[i]                     = b.bubble;
               bus.uhost_req_cmd[i*CW +: CW]     = CW'(i) | (CW'(b.eom) << UMI_EOM_BIT);
               bus.uhost_req_dstaddr[i*AW +: AW] = addr;
               bus.uhost_req_srcaddr[i*AW +: AW] = ~addr;
               bus.uhost_req_data[i*DW +: DW]    = {~addr, addr};
            end
         end
      end
   end

   initial begin
      acc = '0;
      forever begin
         @(negedge clk);
         acc = bus.uhost_req_valid & bus.uhost_req_ready;
      end
   end

   // Monitor: every accepted output beat must be the next expected one.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (bus.udev_req_valid && bus.udev_req_ready) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got %0h expected none at %0t",
                        bus.udev_req_data[15:0], $time);
            end else begin
               e = expq.pop_front();
               check("beat_id",    64'(bus.udev_req_data[15:0]), 64'({e.host, e.tag}));
               check("beat_eom",   64'(bus.udev_req_cmd[UMI_EOM_BIT]), 64'(e.eom));
               check("beat_dst",   bus.udev_req_dstaddr, {48'h0, e.host, e.tag});
               check("beat_src",   bus.udev_req_srcaddr, ~{48'h0, e.host, e.tag});
               check("beat_owner", 64'(arb_owner), 64'(e.host[1:0]));
               check("beat_ready", 64'(bus.uhost_req_ready), 64'(4'b0001 << e.host[1:0]));
            end
         end
      end
   end

   initial begin
      reset              = 1'b1;
      arb_mask           = '0;
      bus.udev_req_ready = 1'b1;

      // Reset held with every host valid; release gives 0,1,2,3.
      for (int i = 0; i < N; i++) begin
         push(i, 8'h10 + 8'(i), 1'b1);
         expect_beat(i, 8'h10 + 8'(i), 1'b1);
      end
      tick();
      tick();
      @(negedge clk);
      check("rst_valid_in", 64'(bus.uhost_req_valid), 64'hF);
      check("rst_udev_valid", 64'(bus.udev_req_valid), 64'd0);
      check("rst_ready", 64'(bus.uhost_req_ready), 64'd0);
      check("rst_owner", 64'(arb_owner), 64'd0);
      check("rst_locked", 64'(arb_locked), 64'd0);
      tick();
      reset = 1'b0;
      drain("drain_rr1");

      // Second round starts again at host 0.
      for (int i = 0; i < N; i++) begin
         push(i, 8'h20 + 8'(i), 1'b1);
         expect_beat(i, 8'h20 + 8'(i), 1'b1);
      end
      drain("drain_rr2");

      // Host 1 three-beat message with a 2-cycle stall on beat 2; host 2 waits.
      push(1, 8'h31, 1'b0); push(1, 8'h32, 1'b0); push(1, 8'h33, 1'b1);
      push(2, 8'h34, 1'b1);
      expect_beat(1, 8'h31, 1'b0); expect_beat(1, 8'h32, 1'b0);
      expect_beat(1, 8'h33, 1'b1); expect_beat(2, 8'h34, 1'b1);
      @(negedge clk);
      tick();
      bus.udev_req_ready = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("stall_rdy2", 64'(bus.uhost_req_ready[2]), 64'd0);
         check("stall_locked", 64'(arb_locked), 64'd1);
         check("stall_id", 64'(bus.udev_req_data[15:0]), 64'h0132);
         if (c == 0) tick();
      end
      tick();
      bus.udev_req_ready = 1'b1;
      @(negedge clk);
      check("b2_rdy2", 64'(bus.uhost_req_ready[2]), 64'd0);
      tick();
      @(negedge clk);
      check("b3_rdy2", 64'(bus.uhost_req_ready[2]), 64'd0);
      tick();
      @(negedge clk);
      check("after_eom_owner", 64'(arb_owner), 64'd2);
      drain("drain_stall");

      // Host 0 drops valid mid-message while host 3 waits.
      push(0, 8'h41, 1'b0); gap(0); gap(0); push(0, 8'h42, 1'b1);
      expect_beat(0, 8'h41, 1'b0); expect_beat(0, 8'h42, 1'b1); expect_beat(3, 8'h43, 1'b1);
      @(negedge clk);
      tick();
      push(3, 8'h43, 1'b1);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("gap_locked", 64'(arb_locked), 64'd1);
         check("gap_valid", 64'(bus.udev_req_valid), 64'd0);
         check("gap_rdy3", 64'(bus.uhost_req_ready[3]), 64'd0);
         check("gap_owner", 64'(arb_owner), 64'd0);
         tick();
      end
      drain("drain_gap");

      // Mask skips host 0; masking host 1 mid-message does not break its grant.
      arb_mask = 4'b0001;
      push(1, 8'h51, 1'b0); push(1, 8'h52, 1'b0); push(1, 8'h53, 1'b1);
      push(0, 8'h54, 1'b1);
      expect_beat(1, 8'h51, 1'b0); expect_beat(1, 8'h52, 1'b0);
      expect_beat(1, 8'h53, 1'b1); expect_beat(0, 8'h54, 1'b1);
      @(negedge clk);
      tick();
      arb_mask = 4'b0011;
      @(negedge clk);
      tick();
      @(negedge clk);
      tick();
      @(negedge clk);
      check("masked_valid", 64'(bus.udev_req_valid), 64'd0);
      check("masked_ready", 64'(bus.uhost_req_ready), 64'd0);
      check("masked_locked", 64'(arb_locked), 64'd0);
      tick();
      arb_mask = 4'b0000;
      drain("drain_mask");

      // Reset pulse while host 2 holds a grant: ptr returns to 0, host 0 wins.
      push(2, 8'h61, 1'b0); push(2, 8'h62, 1'b0); push(2, 8'h63, 1'b1);
      push(0, 8'h64, 1'b1);
      expect_beat(2, 8'h61, 1'b0); expect_beat(0, 8'h64, 1'b1);
      expect_beat(2, 8'h62, 1'b0); expect_beat(2, 8'h63, 1'b1);
      @(negedge clk);
      tick();
      reset = 1'b1;
      @(negedge clk);
      check("midrst_valid", 64'(bus.udev_req_valid), 64'd0);
      check("midrst_ready", 64'(bus.uhost_req_ready), 64'd0);
      check("midrst_owner", 64'(arb_owner), 64'd0);
      check("midrst_locked", 64'(arb_locked), 64'd0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("postrst_locked", 64'(arb_locked), 64'd0);
      drain("drain_midrst");

      // One host streaming back-to-back single-beat messages at full rate.
      for (int k = 0; k < 3; k++) begin
         push(3, 8'h71 + 8'(k), 1'b1);
         expect_beat(3, 8'h71 + 8'(k), 1'b1);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stream_valid", 64'(bus.udev_req_valid), 64'd1);
         tick();
      end
      drain("drain_stream");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
